icache_direct: RTL

- Direct-mapped, read-only instruction cache that services the fetch stage's instruction requests (pc, ce).
- Returns the 32-bit instruction combinationally on a hit.
- On a miss, raises a stall request to the control module and fills a 4-word line from the external instruction bus over a req/ack handshake.
- Sits between the fetch PC logic and the instruction memory bus.

---
 rtl/icache_direct.sv | 117 +++++++++++
 1 files changed

// File: rtl/icache_direct.sv
// icache_direct: direct-mapped, read-only instruction cache with 4-word lines.
// Hits return combinationally; misses stall fetch and fill words 0..3 in order.
module icache_direct #(
    parameter int INDEX_W = 6,
    parameter int TAG_W   = 24
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce_i,
    input  logic [31:0] pc_i,
    input  logic        flush_i,
    output logic [31:0] inst_o,
    output logic        stallreq_o,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_data_i,
    output logic        dbg_state
);
    localparam int LINES = 2 ** INDEX_W;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_t;

    state_t           state;
    logic [LINES-1:0] valid_q;
    logic [TAG_W-1:0] tag_arr [LINES];
    logic [31:0]      data_arr [LINES*4];
    logic [27:0]      miss_line;
    logic [1:0]       cnt;
    logic [1:0]       cnt_next;
    logic             flush_seen;

    logic [TAG_W-1:0]   pc_tag;
    logic [INDEX_W-1:0] pc_index;
    logic [1:0]         pc_word;
    logic [1:0]         unused_pc_bits;
    logic [INDEX_W-1:0] miss_index;
    logic [TAG_W-1:0]   miss_tag;
    logic               hit;

    assign pc_tag         = pc_i[31:32-TAG_W];
    assign pc_index       = pc_i[INDEX_W+3:4];
    assign pc_word        = pc_i[3:2];
    assign unused_pc_bits = pc_i[1:0];
    assign miss_index     = miss_line[INDEX_W-1:0];
    assign miss_tag       = miss_line[27 -: TAG_W];
    assign cnt_next       = cnt + 2'd1;

    // Reset forces both lookup outputs low, whatever ce_i says.
    assign hit = rst & ce_i & valid_q[pc_index] & (tag_arr[pc_index] == pc_tag)
               & (state == IDLE);
    assign inst_o     = hit ? data_arr[{pc_index, pc_word}] : 32'h0;
    assign stallreq_o = rst & ce_i & ~hit;
    assign dbg_state  = (state == FILL);

    // Bus handshake: mem_req_o is held high for the whole fill; every cycle with
    // mem_ack_i high transfers mem_data_i for the current mem_addr_o, and the
    // address advances to the next word on the following edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            valid_q    <= '0;
            cnt        <= 2'd0;
            flush_seen <= 1'b0;
            miss_line  <= '0;
            mem_req_o  <= 1'b0;
            mem_addr_o <= 32'h0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (flush_i) begin
                        valid_q <= '0;
                    end else if (ce_i && !hit) begin
                        miss_line         <= pc_i[31:4];
                        cnt               <= 2'd0;
                        flush_seen        <= 1'b0;
                        valid_q[pc_index] <= 1'b0;
                        mem_req_o         <= 1'b1;
                        mem_addr_o        <= {pc_i[31:4], 4'b0000};
                        state             <= FILL;
                    end
                end
                FILL: begin
                    if (flush_i) begin
                        valid_q    <= '0;
                        flush_seen <= 1'b1;
                    end
                    if (mem_ack_i) begin
                        cnt        <= cnt_next;
                        mem_addr_o <= {miss_line, cnt_next, 2'b00};
                        if (cnt == 2'd3) begin
                            mem_req_o <= 1'b0;
                            state     <= IDLE;
                            // A flush seen at any point of the fill leaves the line invalid.
                            if (!flush_seen && !flush_i) begin
                                valid_q[miss_index] <= 1'b1;
                            end
                        end
                    end
                end
            endcase
        end
    end

    // Arrays carry no reset; valid_q alone decides whether their contents are used.
    always_ff @(posedge clk) begin
        if (rst && state == FILL && mem_ack_i) begin
            data_arr[{miss_index, cnt}] <= mem_data_i;
            if (cnt == 2'd3) begin
                tag_arr[miss_index] <= miss_tag;
            end
        end
    end
endmodule
